// File: rtl/tl_pkg.sv
// Shared types and lamp patterns for the traffic light sequencer.
package tl_pkg;

  typedef enum logic [1:0] {
    RED         = 2'd0,
    YELLOW      = 2'd1,
    GREEN       = 2'd2,
    GREEN_BLINK = 2'd3
  } phase_t;

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  function automatic logic [7:0] ticks_to_load(input int ticks);
    return 8'(ticks - 1);
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// 8-bit loadable down-counter with tick enable, zero flag and force-load.
module tl_phase_timer #(
  parameter logic [7:0] RESET_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load_en,
  input  logic [7:0] load_val,
  input  logic       force_en,
  input  logic [7:0] force_val,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Phase load wins over force, which in turn wins over a tick decrement.
  always_comb begin
    count_d = count_q;
    if (load_en) begin
      count_d = load_val;
    end else if (force_en) begin
      count_d = force_val;
    end else if (tick) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 8'd0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Traffic light phase FSM. Pedestrian request logic is compiled in only when
// the macro TL_PED_REQ_EN is defined.
module traffic_light_sequencer
  import tl_pkg::*;
#(
  parameter int RED_TICKS       = 8,
  parameter int YELLOW_TICKS    = 2,
  parameter int GREEN_TICKS     = 8,
  parameter int BLINK_TICKS     = 4,
  parameter int BLINK_HALF      = 1,
  parameter int PED_GREEN_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [1:0] phase,
  output logic [2:0] lamps,
  output logic [7:0] remain,
  output logic       ped_ack,
  output logic       ped_walk
);

  localparam logic [7:0] RED_LD    = ticks_to_load(RED_TICKS);
  localparam logic [7:0] YELLOW_LD = ticks_to_load(YELLOW_TICKS);
  localparam logic [7:0] GREEN_LD  = ticks_to_load(GREEN_TICKS);
  localparam logic [7:0] BLINK_LD  = ticks_to_load(BLINK_TICKS);
  localparam logic [7:0] HALF_LD   = ticks_to_load(BLINK_HALF);
  localparam logic [7:0] PED_LD    = ticks_to_load(PED_GREEN_TICKS);
  localparam logic [7:0] GREEN_PED_LD = (PED_LD < GREEN_LD) ? PED_LD : GREEN_LD;

  phase_t     phase_q, phase_d;
  logic [7:0] timer_s;
  logic       timer_zero_s;
  logic       advance_s;
  logic       red_entry_s;
  logic [7:0] load_val_s;
  logic       force_s;
  logic       pend_s;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic [2:0] lamps_s;

  tl_phase_timer #(.RESET_VAL(RED_LD)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .load_en   (advance_s),
    .load_val  (load_val_s),
    .force_en  (force_s),
    .force_val (PED_LD),
    .count     (timer_s),
    .zero      (timer_zero_s)
  );

  // Next phase and the duration to load when leaving the current one.
  always_comb begin
    advance_s   = tick & timer_zero_s;
    red_entry_s = advance_s & (phase_q == GREEN_BLINK);
    phase_d     = phase_q;
    load_val_s  = RED_LD;
    if (advance_s) begin
      case (phase_q)
        RED:         begin phase_d = YELLOW;      load_val_s = YELLOW_LD; end
        YELLOW:      begin phase_d = GREEN;       load_val_s = pend_s ? GREEN_PED_LD : GREEN_LD; end
        GREEN:       begin phase_d = GREEN_BLINK; load_val_s = BLINK_LD; end
        GREEN_BLINK: begin phase_d = RED;         load_val_s = RED_LD; end
        default:     begin phase_d = RED;         load_val_s = RED_LD; end
      endcase
    end else begin
      phase_d = phase_q;
    end
    force_s = pend_s & (phase_q == GREEN) & (timer_s > PED_LD);
  end

  // Blink half-period counter; idle outside GREEN_BLINK.
  always_comb begin
    blink_cnt_d = 8'd0;
    blink_on_d  = 1'b0;
    if (phase_q != GREEN_BLINK && phase_d == GREEN_BLINK) begin
      blink_cnt_d = HALF_LD;
      blink_on_d  = 1'b1;
    end else if (phase_q == GREEN_BLINK && phase_d == GREEN_BLINK) begin
      if (tick && blink_cnt_q == 8'd0) begin
        blink_cnt_d = HALF_LD;
        blink_on_d  = ~blink_on_q;
      end else if (tick) begin
        blink_cnt_d = blink_cnt_q - 8'd1;
        blink_on_d  = blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
      end
    end else begin
      blink_cnt_d = 8'd0;
      blink_on_d  = 1'b0;
    end
  end

  // Phase and blink state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= RED;
      blink_cnt_q <= 8'd0;
      blink_on_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    lamps_s = LAMP_RED;
    case (phase_q)
      RED:         lamps_s = LAMP_RED;
      YELLOW:      lamps_s = LAMP_YELLOW;
      GREEN:       lamps_s = LAMP_GREEN;
      GREEN_BLINK: lamps_s = blink_on_q ? LAMP_GREEN : LAMP_OFF;
      default:     lamps_s = LAMP_RED;
    endcase
  end

  assign phase  = phase_q;
  assign lamps  = lamps_s;
  assign remain = timer_s;

`ifdef TL_PED_REQ_EN
  logic ped_req_q;
  logic pending_q, pending_d;
  logic ped_ack_q;
  logic ped_walk_q, ped_walk_d;
  logic accept_s;

  // A request accepted on the RED-entry edge survives that transition.
  always_comb begin
    accept_s = ped_req & ~ped_req_q & ~pending_q;
    if (accept_s) begin
      pending_d = 1'b1;
    end else if (red_entry_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (red_entry_s) begin
      ped_walk_d = 1'b1;
    end else if (phase_d != RED) begin
      ped_walk_d = 1'b0;
    end else begin
      ped_walk_d = ped_walk_q;
    end
  end

  // Pedestrian handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_req_q  <= 1'b0;
      pending_q  <= 1'b0;
      ped_ack_q  <= 1'b0;
      ped_walk_q <= 1'b0;
    end else begin
      ped_req_q  <= ped_req;
      pending_q  <= pending_d;
      ped_ack_q  <= accept_s;
      ped_walk_q <= ped_walk_d;
    end
  end

  assign pend_s   = pending_q;
  assign ped_ack  = ped_ack_q;
  assign ped_walk = ped_walk_q;
`else
  logic ped_req_unused_s;
  logic red_entry_unused_s;

  assign ped_req_unused_s   = ped_req;
  assign red_entry_unused_s = red_entry_s;
  assign pend_s   = 1'b0;
  assign ped_ack  = 1'b0;
  assign ped_walk = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer (RED=4, YELLOW=2, GREEN=6, BLINK=4).
module tb_traffic_light_sequencer;

`ifdef TL_PED_REQ_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       tick;
  logic       ped_req;
  logic [1:0] phase;
  logic [2:0] lamps;
  logic [7:0] remain;
  logic       ped_ack;
  logic       ped_walk;

  int n_chk;
  int n_fail;

  typedef struct {
    logic       tick;
    logic       ped_req;
    logic [1:0] ph;
    logic [2:0] lamps;
    logic [7:0] remain;
    logic       ack;
    logic       walk;
  } vec_t;

  vec_t vecs [32];

  traffic_light_sequencer #(
    .RED_TICKS(4), .YELLOW_TICKS(2), .GREEN_TICKS(6),
    .BLINK_TICKS(4), .BLINK_HALF(1), .PED_GREEN_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
    .phase(phase), .lamps(lamps), .remain(remain),
    .ped_ack(ped_ack), .ped_walk(ped_walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_phase(input logic [1:0] p);
    int n;
    n = 0;
    while (phase != p && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (phase != p) begin
      n_fail++;
      $display("FAIL wait_phase: got %0d, expected %0d within 100 cycles", phase, p);
    end
  endtask

  // Reference schedule of one full cycle (16 ticks) starting at RED entry.
  function automatic void sched(input int m, output logic [1:0] ph,
                                output logic [7:0] rm, output logic [2:0] lp);
    if (m < 4) begin
      ph = 2'd0; rm = 8'(3 - m); lp = 3'b100;
    end else if (m < 6) begin
      ph = 2'd1; rm = 8'(1 - (m - 4)); lp = 3'b010;
    end else if (m < 12) begin
      ph = 2'd2; rm = 8'(5 - (m - 6)); lp = 3'b001;
    end else begin
      ph = 2'd3; rm = 8'(3 - (m - 12)); lp = (((m - 12) % 2) == 0) ? 3'b001 : 3'b000;
    end
  endfunction

  initial begin
    logic [1:0] eph;
    logic [7:0] erm;
    logic [2:0] elp;
    n_chk = 0;
    n_fail = 0;

    for (int k = 0; k < 32; k++) begin
      sched(k % 16, eph, erm, elp);
      vecs[k].tick    = 1'b1;
      vecs[k].ped_req = PED_EN ? 1'b0 : 1'(k % 2);
      vecs[k].ph      = eph;
      vecs[k].remain  = erm;
      vecs[k].lamps   = elp;
      vecs[k].ack     = 1'b0;
      vecs[k].walk    = PED_EN && (k >= 16) && (eph == 2'd0);
    end

    reset = 1'b0;
    tick = 1'b0;
    ped_req = 1'b0;
    #13;
    chk("rst_phase", phase, 0);
    chk("rst_lamps", lamps, 3'b100);
    chk("rst_remain", remain, 3);
    chk("rst_ack", ped_ack, 0);
    chk("rst_walk", ped_walk, 0);
    @(negedge clk);
    reset = 1'b1;

    // Two full cycles with tick every clock.
    for (int k = 0; k < 32; k++) begin
      chk("seq_phase", phase, vecs[k].ph);
      chk("seq_lamps", lamps, vecs[k].lamps);
      chk("seq_remain", remain, vecs[k].remain);
      chk("seq_ack", ped_ack, vecs[k].ack);
      chk("seq_walk", ped_walk, vecs[k].walk);
      tick = vecs[k].tick;
      ped_req = vecs[k].ped_req;
      step();
    end
    ped_req = 1'b0;

    // Tick every third clock: state advances only after tick cycles.
    for (int j = 0; j < 48; j++) begin
      sched(((j + 2) / 3) % 16, eph, erm, elp);
      chk("tick3_phase", phase, eph);
      chk("tick3_remain", remain, erm);
      chk("tick3_lamps", lamps, elp);
      chk("tick3_walk", ped_walk, PED_EN && (eph == 2'd0));
      tick = ((j % 3) == 0);
      step();
    end
    tick = 1'b1;
    chk("tick3_wrap", remain, 3);

    // Asynchronous reset in the middle of GREEN.
    wait_phase(2'd2);
    step();
    chk("pre_rst_remain", remain, 4);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_lamps", lamps, 3'b100);
    chk("async_rst_remain", remain, 3);
    chk("async_rst_walk", ped_walk, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_phase", phase, 0);
      chk("post_rst_remain", remain, 3 - i);
      step();
    end
    chk("post_rst_yellow", phase, 1);

`ifdef TL_PED_REQ_EN
    // Request on the first GREEN cycle shortens GREEN to two more ticks.
    wait_phase(2'd2);
    chk("p1_remain0", remain, 5);
    ped_req = 1'b1;
    step();
    chk("p1_ack", ped_ack, 1);
    chk("p1_remain1", remain, 4);
    step();
    ped_req = 1'b0;
    chk("p1_forced", remain, 1);
    chk("p1_ack_once", ped_ack, 0);
    step();
    chk("p1_remain_last", remain, 0);
    step();
    chk("p1_blink", phase, 3);
    wait_phase(2'd0);
    for (int i = 0; i < 4; i++) begin
      chk("p1_walk", ped_walk, 1);
      chk("p1_red_remain", remain, 3 - i);
      step();
    end
    chk("p1_walk_off", ped_walk, 0);
    wait_phase(2'd2);
    chk("p1_next_green", remain, 5);
    step();
    chk("p1_not_forced", remain, 4);

    // Request held through YELLOW: one ack, GREEN of two ticks.
    wait_phase(2'd1);
    ped_req = 1'b1;
    step();
    chk("p2_ack", ped_ack, 1);
    step();
    chk("p2_green", phase, 2);
    chk("p2_green_remain", remain, 1);
    chk("p2_no_reack", ped_ack, 0);
    step();
    chk("p2_green_last", remain, 0);
    step();
    chk("p2_blink", phase, 3);
    wait_phase(2'd0);
    chk("p2_no_ack_red", ped_ack, 0);
    ped_req = 1'b0;
    step();
    ped_req = 1'b1;
    step();
    chk("p2_reack", ped_ack, 1);
    wait_phase(2'd2);
    chk("p2_short_green", remain, 1);
    ped_req = 1'b0;

    // Request on the GREEN_BLINK -> RED edge survives the transition.
    wait_phase(2'd3);
    step();
    step();
    step();
    chk("p3_blink_last", remain, 0);
    ped_req = 1'b1;
    step();
    chk("p3_red", phase, 0);
    chk("p3_ack", ped_ack, 1);
    chk("p3_walk", ped_walk, 1);
    ped_req = 1'b0;
    wait_phase(2'd2);
    chk("p3_short_green", remain, 1);
`else
    // Pedestrian logic absent: toggling ped_req has no effect.
    for (int i = 0; i < 16; i++) begin
      ped_req = ~ped_req;
      chk("np_ack", ped_ack, 0);
      chk("np_walk", ped_walk, 0);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
